// File: rtl/ball_multi_bounce_if.sv
// ---------------------------------------------------------------------------
// ball_multi_bounce_if
// Bundles the video-path signals between the sync generator side (master)
// and the multi-ball bouncer (slave).
//   vsync, display_on, hpos, vpos, pause : master -> slave
//   rgb, busy, bounce                    : slave  -> master
// ---------------------------------------------------------------------------
interface ball_multi_bounce_if;
    logic       vsync;
    logic       display_on;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       pause;
    logic [2:0] rgb;
    logic       busy;
    logic       bounce;

    modport master (
        output vsync, display_on, hpos, vpos, pause,
        input  rgb, busy, bounce
    );

    modport slave (
        input  vsync, display_on, hpos, vpos, pause,
        output rgb, busy, bounce
    );
endinterface

// File: rtl/ball_multi_bounce.sv
// ---------------------------------------------------------------------------
// ball_multi_bounce
// Multi-ball bouncer for the 640x480 VGA demo path. Holds NUM_BALLS balls,
// moves them once per frame with a one-ball-per-cycle update engine that
// reflects off all four screen edges, and renders them over a dot grid
// through a registered RGB output.
// Ports:
//   clk    : pixel clock
//   reset  : synchronous, active-high; reloads all balls and idles the engine
//   vid    : slave modport carrying vsync/display_on/hpos/vpos/pause in and
//            rgb ({b,g,r}, registered), busy, bounce (one-cycle pulse) out
// ---------------------------------------------------------------------------
module ball_multi_bounce #(
    parameter int NUM_BALLS = 4,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int BALL_SIZE = 8,
    parameter int SPEED     = 2
) (
    input  logic               clk,
    input  logic               reset,
    ball_multi_bounce_if.slave vid
);

    localparam logic [9:0] XMAX      = 10'(H_ACTIVE - BALL_SIZE);
    localparam logic [9:0] YMAX      = 10'(V_ACTIVE - BALL_SIZE);
    localparam logic [4:0] SPEED_POS = 5'(SPEED);
    localparam logic [4:0] SPEED_NEG = 5'(-SPEED);
    localparam logic [2:0] LAST_IDX  = 3'(NUM_BALLS - 1);
    localparam logic [9:0] SIZE10    = 10'(BALL_SIZE);

    typedef enum logic {IDLE, UPDATE} state_t;

    state_t state_q, state_d;
    logic [2:0] idx_q, idx_d;

    logic vsPrev_q;
    logic vsRise_q;

    logic [NUM_BALLS-1:0][9:0] ballX_q;
    logic [NUM_BALLS-1:0][9:0] ballY_q;
    logic [NUM_BALLS-1:0][4:0] ballDx_q;
    logic [NUM_BALLS-1:0][4:0] ballDy_q;

    logic [9:0]  curX, curY;
    logic [4:0]  curDx, curDy;
    logic [15:0] xStep_d, yStep_d;

    logic       bounce_q;
    logic [2:0] pix_d;
    logic [2:0] rgb_q;

    // One axis of motion. Packs {reflected, new velocity, new position}.
    // Reflection forces an absolute direction rather than negating, so a
    // ball parked on an edge can never bounce back into it.
    function automatic logic [15:0] stepAxis(input logic [9:0] pos,
                                             input logic [4:0] vel,
                                             input logic [9:0] lim);
        logic signed [10:0] nxt;
        logic signed [10:0] lim11;
        nxt   = signed'({1'b0, pos}) + signed'({{6{vel[4]}}, vel});
        lim11 = signed'({1'b0, lim});
        if (nxt <= 11'sd0) begin
            return {1'b1, SPEED_POS, 10'd0};
        end else if (nxt >= lim11) begin
            return {1'b1, SPEED_NEG, lim};
        end else begin
            return {1'b0, vel, nxt[9:0]};
        end
    endfunction

    // vsync rising-edge detector; the rise flag is registered so the
    // engine starts two cycles after vsync is first seen high.
    always_ff @(posedge clk) begin
        if (reset) begin
            vsPrev_q <= 1'b0;
            vsRise_q <= 1'b0;
        end else begin
            vsPrev_q <= vid.vsync;
            vsRise_q <= !vsPrev_q && vid.vsync;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // FSM next state: pause only matters at the moment a pass would start
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (vsRise_q && !vid.pause) begin
                    state_d = UPDATE;
                    idx_d   = 3'd0;
                end
            end
            UPDATE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = 3'd0;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        vid.busy = (state_q == UPDATE);
    end

    // Pick the ball under update and compute its next state for both axes
    always_comb begin
        curX  = 10'd0;
        curY  = 10'd0;
        curDx = 5'd0;
        curDy = 5'd0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (idx_q == 3'(i)) begin
                curX  = ballX_q[i];
                curY  = ballY_q[i];
                curDx = ballDx_q[i];
                curDy = ballDy_q[i];
            end
        end
        xStep_d = stepAxis(curX, curDx, XMAX);
        yStep_d = stepAxis(curY, curDy, YMAX);
    end

    // Ball state and bounce pulse. Reset reloads every ball, so a pass
    // interrupted by reset leaves nothing half updated.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                ballX_q[i]  <= 10'(H_ACTIVE / 2 - 32 * i);
                ballY_q[i]  <= 10'(V_ACTIVE / 2 - 16 * i);
                ballDx_q[i] <= (i % 2 == 1)       ? SPEED_POS : SPEED_NEG;
                ballDy_q[i] <= ((i / 2) % 2 == 1) ? SPEED_NEG : SPEED_POS;
            end
            bounce_q <= 1'b0;
        end else begin
            bounce_q <= 1'b0;
            if (state_q == UPDATE) begin
                for (int i = 0; i < NUM_BALLS; i++) begin
                    if (idx_q == 3'(i)) begin
                        ballX_q[i]  <= xStep_d[9:0];
                        ballDx_q[i] <= xStep_d[14:10];
                        ballY_q[i]  <= yStep_d[9:0];
                        ballDy_q[i] <= yStep_d[14:10];
                    end
                end
                bounce_q <= xStep_d[15] | yStep_d[15];
            end
        end
    end

    // Pixel colour. Walking from the highest index down lets the lowest
    // index overwrite last, so it wins on overlap. Unsigned wrap of the
    // differences makes "left of / above the ball" fail the range test.
    always_comb begin
        logic [9:0] dh;
        logic [9:0] dv;
        dh    = 10'd0;
        dv    = 10'd0;
        pix_d = ((vid.hpos[2:0] == 3'd0) && (vid.vpos[2:0] == 3'd0)) ? 3'b010 : 3'b000;
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            dh = vid.hpos - ballX_q[i];
            dv = vid.vpos - ballY_q[i];
            if ((dh < SIZE10) && (dv < SIZE10)) begin
                pix_d = 3'((i % 7) + 1);
            end
        end
        if (!vid.display_on) begin
            pix_d = 3'b000;
        end
    end

    // Registered RGB output
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q <= 3'b000;
        end else begin
            rgb_q <= pix_d;
        end
    end

    assign vid.rgb    = rgb_q;
    assign vid.bounce = bounce_q;

endmodule

// File: tb/tb_ball_multi_bounce.sv
// ---------------------------------------------------------------------------
// tb_ball_multi_bounce
// Directed bench for ball_multi_bounce with default parameters (4 balls,
// 640x480, size 8, speed 2). Expected ball positions are hand-computed from
// the motion rules; ball state is observed through hierarchical reads.
// ---------------------------------------------------------------------------
module tb_ball_multi_bounce;

    localparam logic [4:0] POS = 5'd2;
    localparam logic [4:0] NEG = 5'd30;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    ball_multi_bounce_if vid ();

    ball_multi_bounce #(
        .NUM_BALLS (4),
        .H_ACTIVE  (640),
        .V_ACTIVE  (480),
        .BALL_SIZE (8),
        .SPEED     (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .vid   (vid.slave)
    );

    // 100 MHz-style free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every comparison goes through here
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packs one ball's state as {x, y, dx, dy}
    function automatic logic [31:0] ballState(input int i);
        return {2'b00, dut.ballX_q[i], dut.ballY_q[i], dut.ballDx_q[i], dut.ballDy_q[i]};
    endfunction

    function automatic logic [31:0] packBall(input int x, input int y, input logic [4:0] dx, input logic [4:0] dy);
        return {2'b00, 10'(x), 10'(y), dx, dy};
    endfunction

    // One short frame: vsync high for one cycle, then low for seven,
    // counting busy cycles and bounce pulses along the way
    task automatic applyStimulus(output int busyCnt, output int bounceCnt);
        busyCnt   = 0;
        bounceCnt = 0;
        vid.vsync = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            vid.vsync = 1'b0;
            if (vid.busy)   busyCnt++;
            if (vid.bounce) bounceCnt++;
        end
    endtask

    task automatic checkResetBalls(input string tag);
        checkOutput({tag, "_b0"}, ballState(0), packBall(320, 240, NEG, POS));
        checkOutput({tag, "_b1"}, ballState(1), packBall(288, 224, POS, POS));
        checkOutput({tag, "_b2"}, ballState(2), packBall(256, 208, NEG, NEG));
        checkOutput({tag, "_b3"}, ballState(3), packBall(224, 192, POS, NEG));
    endtask

    task automatic setBeam(input int h, input int v, input logic on);
        vid.hpos       = 10'(h);
        vid.vpos       = 10'(v);
        vid.display_on = on;
        tick();
    endtask

    // Main directed sequence
    initial begin
        int busyCnt;
        int bounceCnt;
        int busyTotal;

        errors         = 0;
        checks         = 0;
        reset          = 1'b1;
        vid.vsync      = 1'b0;
        vid.display_on = 1'b0;
        vid.hpos       = 10'd0;
        vid.vpos       = 10'd0;
        vid.pause      = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        checkOutput("rst_rgb", 32'(vid.rgb), 32'd0);
        checkOutput("rst_busy", 32'(vid.busy), 32'd0);
        checkOutput("rst_bounce", 32'(vid.bounce), 32'd0);
        checkResetBalls("rst");

        // First frame, cycle by cycle
        vid.vsync = 1'b1;
        tick();
        vid.vsync = 1'b0;
        checkOutput("f1_busy_E1", 32'(vid.busy), 32'd0);
        tick();
        checkOutput("f1_busy_E2", 32'(vid.busy), 32'd1);
        checkOutput("f1_b0_E2", ballState(0), packBall(320, 240, NEG, POS));
        tick();
        checkOutput("f1_b0_E3", ballState(0), packBall(318, 242, NEG, POS));
        busyCnt   = 2;
        bounceCnt = vid.bounce ? 1 : 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (vid.busy)   busyCnt++;
            if (vid.bounce) bounceCnt++;
        end
        checkOutput("f1_busy_cycles", 32'(busyCnt), 32'd4);
        checkOutput("f1_bounce", 32'(bounceCnt), 32'd0);

        // Frames 2..161: ball0 reaches the bottom edge at 116, left edge at 160
        busyTotal = 0;
        for (int f = 2; f <= 161; f++) begin
            applyStimulus(busyCnt, bounceCnt);
            busyTotal += busyCnt;
            if (f == 116) begin
                checkOutput("f116_b0", ballState(0), packBall(88, 472, NEG, NEG));
                checkOutput("f116_bounce", 32'(bounceCnt), 32'd1);
            end
            if (f == 160) begin
                checkOutput("f160_b0", ballState(0), packBall(0, 384, POS, NEG));
                checkOutput("f160_bounce", 32'(bounceCnt), 32'd1);
            end
        end
        checkOutput("f161_b0", ballState(0), packBall(2, 382, POS, NEG));
        checkOutput("busy_total", 32'(busyTotal), 32'(4 * 160));

        // Pause across five vsync rises
        vid.pause = 1'b1;
        busyTotal = 0;
        for (int f = 0; f < 5; f++) begin
            applyStimulus(busyCnt, bounceCnt);
            busyTotal += busyCnt;
        end
        checkOutput("pause_busy", 32'(busyTotal), 32'd0);
        checkOutput("pause_b0", ballState(0), packBall(2, 382, POS, NEG));
        checkOutput("pause_b1", ballState(1), packBall(610, 398, POS, NEG));
        checkOutput("pause_b2", ballState(2), packBall(66, 114, POS, POS));
        checkOutput("pause_b3", ballState(3), packBall(546, 130, POS, POS));
        vid.pause = 1'b0;
        applyStimulus(busyCnt, bounceCnt);
        checkOutput("unpause_busy", 32'(busyCnt), 32'd4);
        checkOutput("unpause_b0", ballState(0), packBall(4, 380, POS, NEG));

        // Rendering with ball0 at (100,100) overlapping ball1 at (104,104)
        force dut.ballX_q = {10'd500, 10'd400, 10'd104, 10'd100};
        force dut.ballY_q = {10'd400, 10'd300, 10'd104, 10'd100};
        setBeam(105, 105, 1'b1);
        checkOutput("rgb_overlap", 32'(vid.rgb), 32'b001);
        setBeam(110, 110, 1'b1);
        checkOutput("rgb_ball1", 32'(vid.rgb), 32'b010);
        setBeam(503, 407, 1'b1);
        checkOutput("rgb_ball3", 32'(vid.rgb), 32'b100);
        setBeam(107, 103, 1'b1);
        checkOutput("rgb_edge_in", 32'(vid.rgb), 32'b001);
        setBeam(108, 100, 1'b1);
        checkOutput("rgb_edge_out", 32'(vid.rgb), 32'b000);
        setBeam(8, 8, 1'b1);
        checkOutput("rgb_grid", 32'(vid.rgb), 32'b010);
        setBeam(9, 8, 1'b1);
        checkOutput("rgb_blank", 32'(vid.rgb), 32'b000);
        setBeam(105, 105, 1'b0);
        checkOutput("rgb_display_off", 32'(vid.rgb), 32'b000);
        release dut.ballX_q;
        release dut.ballY_q;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkResetBalls("rst2");

        // Reset asserted during E+3 of a pass
        vid.vsync = 1'b1;
        tick();
        vid.vsync = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midrst_busy", 32'(vid.busy), 32'd0);
        checkResetBalls("midrst");
        for (int c = 0; c < 4; c++) tick();
        applyStimulus(busyCnt, bounceCnt);
        checkOutput("midrst_next_busy", 32'(busyCnt), 32'd4);
        checkOutput("midrst_next_b0", ballState(0), packBall(318, 242, NEG, POS));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ball_multi_bounce.md
# ball_multi_bounce

Parametrised multi-ball bouncer for the VGA video path. It sits between the sync generator and the RGB output pins, alongside the other 640x480 demo generators. It holds NUM_BALLS balls, each with its own position, velocity and colour. Positions are updated once per frame by a sequential update engine that reflects each ball off all four screen edges. The block renders the balls with fixed priority over a dot-grid background through a registered RGB output.

## Interface
Parameters:
- NUM_BALLS, 4 — number of balls, 1..8.
- H_ACTIVE, 640 — visible width in pixels.
- V_ACTIVE, 480 — visible height in pixels.
- BALL_SIZE, 8 — ball edge length in pixels, 1..32.
- SPEED, 2 — per-frame step magnitude in pixels, 1..15.

Ports:
- clk  in  1  — pixel clock; single clock domain.
- reset  in  1  — synchronous, active-high.
- vsync  in  1  — vertical sync from the sync generator; active-high.
- display_on  in  1  — high during the visible region.
- hpos  in  10  — current beam X.
- vpos  in  10  — current beam Y.
- pause  in  1  — freezes motion while high.
- rgb  out  3  — {b,g,r} pixel colour, registered.
- busy  out  1  — high while the update engine is processing balls.
- bounce  out  1  — one-cycle pulse when any ball reflects during a frame update.

## Operation
- Per-ball state, for ball i:
  - x_i, y_i: 10-bit unsigned.
  - dx_i, dy_i: 5-bit two's complement, magnitude always SPEED.
- Reset values:
  - x_i = H_ACTIVE/2 − 32·i; y_i = V_ACTIVE/2 − 16·i.
  - dx_i = +SPEED if i[0] is 1, else −SPEED.
  - dy_i = −SPEED if i[1] is 1, else +SPEED.
  - Outputs: rgb=0, busy=0, bounce=0.
- Limits: XMAX = H_ACTIVE − BALL_SIZE; YMAX = V_ACTIVE − BALL_SIZE.
- vsync edge detection: r_vsync is registered. vs_rise is registered as (!r_vsync && vsync).
- FSM states: IDLE, UPDATE.
  - IDLE → UPDATE when vs_rise=1 and pause=0. Index k is set to 0.
  - UPDATE: processes ball k in one cycle, then k increments.
  - UPDATE → IDLE after the cycle with k = NUM_BALLS−1.
  - vs_rise while in UPDATE is ignored.
  - busy = (state == UPDATE).
- Per-axis update, shown for X (Y is identical with y/dy/YMAX):
  - nx = x + dx, computed in 11-bit signed.
  - If nx ≤ 0: x ← 0, dx ← +SPEED, reflect flag set.
  - Else if nx ≥ XMAX: x ← XMAX, dx ← −SPEED, reflect flag set.
  - Else: x ← nx.
  - Using absolute direction means a clamped ball never double-reflects.
  - X and Y may both reflect in the same cycle (corner hit); both flags set.
- bounce: registered OR of both reflect flags from the current UPDATE cycle. It is high the cycle after the reflecting ball's update.
- Rendering, combinational hit test:
  - hit_i = (hpos − x_i) < BALL_SIZE and (vpos − y_i) < BALL_SIZE, using 10-bit unsigned differences.
  - Ball colour c_i = (i mod 7) + 1.
  - Lowest index wins on overlap.
  - No hit: rgb = 3'b010 if hpos[2:0]==0 and vpos[2:0]==0, else 0.
  - display_on low forces 0.
- pause is sampled only in IDLE when vs_rise is high. Setting pause mid-UPDATE does not abort the current pass.
- reset in any state: returns FSM to IDLE immediately and reloads all balls. Reset mid-UPDATE leaves no partially updated balls.

## Timing
- Let E be the first cycle vsync is sampled 1 after being 0. vs_rise is high in cycle E+1.
- UPDATE runs in cycles E+2 .. E+1+NUM_BALLS.
- Ball i's new state is visible from cycle E+3+i.
- busy is high for exactly NUM_BALLS cycles per unpaused frame.
- rgb latency is 1 cycle: rgb in cycle t+1 reflects hpos, vpos, display_on and ball state at cycle t.
- Updates complete within vertical blanking for any legal NUM_BALLS, so there is no tearing.

## Test plan
- Reset, defaults → ball0 (320,240,−2,+2), ball1 (288,224,+2,+2), ball2 (256,208,−2,−2), ball3 (224,192,+2,−2); rgb=0, busy=0, bounce=0.
- One vsync rise with pause=0 → busy high 4 cycles starting E+2; ball0 at (318,242) from E+3; no bounce pulse.
- 160 frames → ball0 x=0, dx=+2, bounce pulses once in that frame; frame 161 → x=2. Frame 116 → ball0 y=472, dy=−2.
- pause=1 across 5 vsync rises → busy never asserts; all positions unchanged. Release pause → the next frame moves normally.
- Force ball0 and ball1 to overlap, beam inside both → rgb=3'b001 (ball0 wins); beam at (8,8) outside balls → 3'b010; display_on=0 → 3'b000.
- Assert reset during E+3 of an update → busy=0 in the next cycle; all balls at reset values; the next vsync runs a full 4-cycle pass.
